// File: rtl/bus_bridge_pkg.sv
// Shared request/response types and frame constants for the UART bus-bridge link.
package bus_bridge_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        is_write;
  } bus_bridge_req_t;

  typedef struct packed {
    logic [7:0] read_data;
    logic       is_write;
  } bus_bridge_resp_t;

  localparam int         REQ_FRAME_BYTES   = 4;
  localparam int         RESP_FRAME_BYTES  = 2;
  localparam logic [7:0] TIMEOUT_READ_DATA = 8'hFF;

  // Request frame byte order: addr lo, addr hi, write data, flags.
  function automatic logic [7:0] req_frame_byte(bus_bridge_req_t r, logic [1:0] idx);
    case (idx)
      2'd0:    return r.addr[7:0];
      2'd1:    return r.addr[15:8];
      2'd2:    return r.write_data;
      default: return {7'b0, r.is_write};
    endcase
  endfunction

endpackage

// File: rtl/uart.sv
// 8N1 UART: shift-register transmitter plus mid-bit sampling receiver with sticky ready.
module uart #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_en,
  input  logic                 clear,
  output logic                 Tx,
  output logic                 Tx_busy,
  input  logic                 Rx,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int         FRAME      = DATA_BITS + 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2);
  localparam logic [3:0] FRAME_LAST = 4'(FRAME - 1);

  logic [FRAME-1:0]     tx_sh;
  logic [15:0]          tx_cnt, rx_cnt;
  logic [3:0]           tx_bit, rx_bit;
  logic [1:0]           rx_sync;
  logic                 rx_active;
  logic [DATA_BITS-1:0] rx_sh;

  assign Tx = tx_sh[0];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '1;
      Tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!Tx_busy) begin
      if (wr_en) begin
        tx_sh   <= {1'b1, data_in, 1'b0};
        Tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      tx_sh  <= {1'b1, tx_sh[FRAME-1:1]};
      tx_bit <= tx_bit + 4'd1;
      if (tx_bit == FRAME_LAST) Tx_busy <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // Start edge preloads the counter by half a bit so samples land mid-bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync   <= 2'b11;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      ready     <= 1'b0;
      data_out  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], Rx};
      if (clear) begin
        rx_active <= 1'b0;
        ready     <= 1'b0;
      end else begin
        if (ready_clr) ready <= 1'b0;
        if (!rx_active) begin
          if (!rx_sync[1]) begin
            rx_active <= 1'b1;
            rx_cnt    <= HALF_BIT;
            rx_bit    <= '0;
          end
        end else if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == 4'd0) begin
            if (rx_sync[1]) rx_active <= 1'b0;
          end else if (rx_bit == FRAME_LAST) begin
            rx_active <= 1'b0;
            ready     <= 1'b1;
            data_out  <= rx_sh;
          end else begin
            rx_sh <= {rx_sync[1], rx_sh[DATA_BITS-1:1]};
          end
        end else begin
          rx_cnt <= rx_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_bridge_target_uart_wrapper.sv
// Target-side UART bridge: request stream -> 4-byte frame out, 2-byte frame in -> response stream.
// Optional response timeout enabled by defining BUS_BRIDGE_UART_TIMEOUT_EN.
module bus_bridge_target_uart_wrapper
  import bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CLKS_PER_BIT   = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic             uart_tx,
  input  logic             req_valid,
  output logic             req_ready,
  input  bus_bridge_req_t  req_payload,
  output logic             resp_valid,
  input  logic             resp_ready,
  output bus_bridge_resp_t resp_payload
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_TX, WAIT_RESP_DATA, WAIT_RESP_FLAGS, RESP_HOLD
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(REQ_FRAME_BYTES - 1);

  state_t          state, state_nxt;
  bus_bridge_req_t req_q;
  logic [1:0]      idx;
  logic            wr_en, ready_clr, tx_busy, rx_ready, busy_q, rdy_q;
  logic [7:0]      tx_data, rx_data;
  logic            tx_done, rx_evt, in_wait_resp, to_fire;

  assign tx_done      = busy_q & ~tx_busy;
  assign rx_evt       = rx_ready & ~rdy_q;
  assign in_wait_resp = (state == WAIT_RESP_DATA) || (state == WAIT_RESP_FLAGS);
  assign req_ready    = (state == IDLE);

`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
  logic [31:0] to_cnt;

  // A byte landing on the timeout cycle wins over the timeout.
  assign to_fire = in_wait_resp && !rx_evt && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                to_cnt <= '0;
    else if (rx_evt || (state == WAIT_TX && tx_done && idx == LAST_IDX)) to_cnt <= '0;
    else if (in_wait_resp)                                     to_cnt <= to_cnt + 32'd1;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (req_valid) state_nxt = SEND;
      SEND:            if (!tx_busy) state_nxt = WAIT_TX;
      WAIT_TX:         if (tx_done) state_nxt = (idx == LAST_IDX) ? WAIT_RESP_DATA : SEND;
      WAIT_RESP_DATA:  if (rx_evt) state_nxt = WAIT_RESP_FLAGS;
                       else if (to_fire) state_nxt = RESP_HOLD;
      WAIT_RESP_FLAGS: if (rx_evt || to_fire) state_nxt = RESP_HOLD;
      RESP_HOLD:       if (resp_ready) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      idx          <= '0;
      wr_en        <= 1'b0;
      tx_data      <= '0;
      ready_clr    <= 1'b0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_payload <= '0;
    end else begin
      busy_q    <= tx_busy;
      rdy_q     <= rx_ready;
      ready_clr <= rx_evt;
      wr_en     <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          req_q <= req_payload;
          idx   <= '0;
        end
        SEND: if (!tx_busy) begin
          wr_en   <= 1'b1;
          tx_data <= req_frame_byte(req_q, idx);
        end
        WAIT_TX: if (tx_done && idx != LAST_IDX) idx <= idx + 2'd1;
        WAIT_RESP_DATA, WAIT_RESP_FLAGS: begin
          if (rx_evt) begin
            if (state == WAIT_RESP_DATA) resp_payload.read_data <= rx_data;
            else begin
              resp_payload.is_write <= rx_data[0];
              resp_valid            <= 1'b1;
            end
          end else if (to_fire) begin
            resp_payload.read_data <= TIMEOUT_READ_DATA;
            resp_payload.is_write  <= req_q.is_write;
            resp_valid             <= 1'b1;
          end
        end
        RESP_HOLD: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  uart #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_50m  (clk),
    .rst_n    (rst_n),
    .data_in  (tx_data),
    .wr_en    (wr_en),
    .clear    (1'b0),
    .Tx       (uart_tx),
    .Tx_busy  (tx_busy),
    .Rx       (uart_rx),
    .ready    (rx_ready),
    .ready_clr(ready_clr),
    .data_out (rx_data)
  );

endmodule

// File: doc/bus_bridge_target_uart_wrapper.md
# bus_bridge_target_uart_wrapper

Target-side end of the UART bus-bridge link. It accepts a bus request from the local target-side bridge logic over a valid/ready stream and serialises it onto UART as a 4-byte request frame. It then collects the 2-byte response frame from UART and returns it on a valid/ready response stream. It is the counterpart of the initiator-side UART wrapper, and together they tunnel one serial-bus transaction at a time across a UART link.

## Interface
- TIMEOUT_CYCLES, 1_000_000: response-wait limit in clk cycles; used only with the timeout feature compiled in.
- clk  in  1  system clock, also feeds uart clk_50m.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input carrying response frames.
- uart_tx  out  1  serial output carrying request frames; idle high.
- req_valid  in  1  request payload valid.
- req_ready  out  1  block can accept a request.
- req_payload  in  bus_bridge_req_t  fields addr[15:0], write_data[7:0], is_write.
- resp_valid  out  1  response payload valid.
- resp_ready  in  1  consumer accepts response.
- resp_payload  out  bus_bridge_resp_t  fields read_data[7:0], is_write.

## Operation
- One outstanding transaction; no queueing.
- States: IDLE, SEND, WAIT_TX, WAIT_RESP_DATA, WAIT_RESP_FLAGS, RESP_HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch payload, byte index <= 0, go SEND.
- SEND:
  - When !Tx_busy: load the byte selected by the index and pulse uart wr_en for 1 cycle, then go WAIT_TX.
  - Byte 0 = addr[7:0]; byte 1 = addr[15:8]; byte 2 = write_data (sent even for reads); byte 3 = {7'b0, is_write}.
- WAIT_TX:
  - On tx_done (Tx_busy falling edge): if index==3 go WAIT_RESP_DATA, else index+1 and go SEND.
- WAIT_RESP_DATA:
  - On rx byte: read_data <= byte, go WAIT_RESP_FLAGS.
- WAIT_RESP_FLAGS:
  - On rx byte: resp is_write <= byte[0], resp_valid <= 1, go RESP_HOLD.
- RESP_HOLD:
  - On resp_valid&&resp_ready: resp_valid <= 0, go IDLE.
- Rx byte event = rising edge of uart ready (registered edge detect).
- Every rx byte event pulses ready_clr for 1 cycle, in all states.
- Bytes arriving outside the WAIT_RESP_* states are discarded.
- Response flag bits [7:1] are ignored.

## Timing
- Reset values:
  - state IDLE, so req_ready=1.
  - resp_valid=0, resp_payload=0.
  - uart wr_en=0, ready_clr=0, tx data=0.
  - Edge-detect flops 0.
- req_ready is combinational from state (IDLE only); resp_valid and resp_payload are registered.
- Request accepted in cycle N: state is SEND at N+1, and wr_en is high at N+2 if the UART is idle.
- Between request bytes there is one SEND cycle after tx_done.
- Response delivery: resp_valid rises the cycle after the flag-byte rx event.
- resp_payload is stable while resp_valid=1.
- If resp_valid&&resp_ready in cycle M: req_ready=1 at M+1, and a new request can be accepted at M+1.
- Reset asserted mid-frame: immediately IDLE, and any partial frame is abandoned.

## Configuration
- Macro BUS_BRIDGE_UART_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RESP_DATA and on each rx byte event, and increments in WAIT_RESP_*.
  - On reaching TIMEOUT_CYCLES-1: resp read_data=8'hFF, is_write=latched request is_write, resp_valid <= 1, go RESP_HOLD.
  - Late bytes after the timeout are discarded.
- Undefined:
  - No counter; the block waits indefinitely for the response.
  - TIMEOUT_CYCLES is unused.

## Structure
- bus_bridge_pkg already holds bus_bridge_req_t and bus_bridge_resp_t.
- Add the frame constants to bus_bridge_pkg: REQ_FRAME_BYTES=4, RESP_FRAME_BYTES=2, TIMEOUT_READ_DATA=8'hFF.
- State enum local to the module.
- One sub-module: existing uart instance (DATA_BITS=8, clear tied 0).

## Test plan
- Write, addr 16'h1234, data 8'hAB -> uart_tx bytes 34,12,AB,01 in order; inject 00,01 -> resp_valid with read_data=00, is_write=1, then req_ready=1.
- Read, addr 16'h00FF -> bytes FF,00,00,00; inject 5A,00 -> read_data=5A, is_write=0.
- Hold resp_ready=0 for 20 cycles after response -> resp_valid and payload stable, req_ready=0, a second req_valid not accepted until the handshake.
- Stray byte 77 injected in IDLE -> no resp_valid; the next transaction completes normally with its own data.
- With BUS_BRIDGE_UART_TIMEOUT_EN and TIMEOUT_CYCLES=500, read with no response -> resp_valid at ~500 cycles after frame sent, read_data=FF.
- rst_n pulsed after byte 1 sent -> req_ready=1, resp_valid=0; a fresh request sends a full 4-byte frame.
